pipe_stage_reg: RTL and testbench
=================================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 The block SHALL have parameter DATA_W, default 230, meaning the payload width of one pipeline beat (IR, PC4, PC8, RS, RT, EXT, write register, start).
REQ-002 The block SHALL have parameter CNT_W, default 16, meaning the width of the flush-drop counter.
REQ-003 Port clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  SHALL be the reset: synchronous, active-low.
REQ-005 Port flush  input  1  SHALL discard every held beat at the next edge.
REQ-006 Port in_valid  input  1  SHALL mean the upstream stage offers a beat.
REQ-007 Port in_ready  output  1  SHALL mean the block accepts a beat this cycle.
REQ-008 Port in_data  input  DATA_W  SHALL carry the upstream payload.
REQ-009 Port out_valid  output  1  SHALL mean out_data holds a valid beat.
REQ-010 Port out_ready  input  1  SHALL mean the downstream stage consumes the beat this cycle.
REQ-011 Port out_data  output  DATA_W  SHALL carry the payload of the head beat.
REQ-012 Port occupancy  output  2  SHALL report the number of held beats (0..2).
REQ-013 Port drop_cnt  output  CNT_W  SHALL count valid beats discarded by flush.

Function
REQ-014 An input transfer SHALL occur on an edge where in_valid && in_ready; an output transfer SHALL occur on an edge where out_valid && out_ready.
REQ-015 Beats SHALL leave in acceptance order, with no loss or duplication except through flush.
REQ-016 Latency SHALL be one cycle: a beat accepted at edge N SHALL appear on out_data after edge N when the block was empty.
REQ-017 out_data SHALL be all-zero whenever out_valid is 0 (bubble is a zeroed beat).
REQ-018 While out_valid && !out_ready, out_data and out_valid SHALL hold stable.
REQ-019 While flush is 1, in_ready SHALL be 0.
REQ-020 On an edge with flush=1, all entries SHALL be cleared: out_valid=0, out_data=0, occupancy=0.
REQ-021 On a flush edge, drop_cnt SHALL add the number of valid entries held, saturating at all-ones; an out transfer on the same edge SHALL still complete, and that beat SHALL NOT be counted.
REQ-022 Simultaneous input and output transfer at occupancy 1 SHALL leave occupancy 1 with the new beat at the head.
REQ-023 occupancy SHALL never exceed the entry count of the configured variant.

Reset
REQ-024 On an edge with reset=0, the block SHALL set out_valid=0, out_data=0, occupancy=0, drop_cnt=0, and internal skid entries empty and zero; reset SHALL take priority over flush and transfers.
REQ-025 in_ready SHALL be 0 during reset and SHALL go to 1 in the first cycle after reset is released.
REQ-026 Reset asserted mid-operation SHALL discard held beats without counting them in drop_cnt.

Configuration
REQ-027 Macro PIPE_STAGE_SKID_EN SHALL select the buffering variant.
REQ-028 Without PIPE_STAGE_SKID_EN, the block SHALL hold one entry, and in_ready = !flush && (!out_valid || out_ready), combinationally.
REQ-029 With PIPE_STAGE_SKID_EN, the block SHALL hold two entries (head plus skid).
REQ-030 In the two-entry variant, in_ready SHALL be driven from a register equal to "skid empty", gated by flush and reset.
REQ-031 In the two-entry variant, a beat accepted while the head is held SHALL go into skid; on a head out transfer, skid SHALL move to the head, and in_ready SHALL rise at the following edge.

Verification
REQ-032 Reset, then stream: reset=0 for 2 cycles, then in_valid=1 with data 1,2,3 and out_ready=1 -> out_data 1,2,3 on consecutive cycles, each one cycle after acceptance.
REQ-033 Backpressure: hold out_ready=0 with a beat 0xA5 held -> out_data stays 0xA5; 1-entry variant: in_ready=0; skid variant: accepts one more beat (0x5A), then in_ready=0 and occupancy=2.
REQ-034 Skid release: out_ready=1 after the previous scenario -> out 0xA5 then 0x5A; in_ready returns to 1 one edge after 0xA5 leaves.
REQ-035 Flush: occupancy=2 and out_ready=0, pulse flush -> out_valid=0, out_data=0, drop_cnt +2; in_ready=0 during the pulse.
REQ-036 Saturation and mid-run reset: drop_cnt preloaded via flushes to 0xFFFF, flush again -> stays 0xFFFF; reset=0 mid-stream -> all outputs 0, and the next beat passes with one-cycle latency.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - valid/ready pipeline stage register with optional skid entry and flush-drop counter
//
// Purpose:
//   Registers one pipeline beat (IR, PC4, PC8, RS, RT, EXT, write register,
//   start) between two stages with valid/ready handshaking. A flush empties
//   the stage and counts the discarded beats. A bubble is always a zeroed beat.
//
// Build option:
//   PIPE_STAGE_SKID_EN  defined   -> two entries (head + skid), in_ready from a register
//                       undefined -> one entry, in_ready combinational from out_ready
//
// Ports:
//   clk        in   1       rising-edge clock
//   reset      in   1       synchronous reset, active low
//   flush      in   1       discard every held beat at the next edge
//   in_valid   in   1       upstream offers a beat
//   in_ready   out  1       stage accepts a beat this cycle
//   in_data    in   DATA_W  upstream payload
//   out_valid  out  1       out_data holds a valid beat
//   out_ready  in   1       downstream consumes the head beat this cycle
//   out_data   out  DATA_W  head beat payload, zero when out_valid is 0
//   occupancy  out  2       number of held beats
//   drop_cnt   out  CNT_W   saturating count of valid beats discarded by flush

module pipe_stage_reg #(
  parameter int DATA_W = 230,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  drop_cnt
);

  logic              r_head_valid;
  logic [DATA_W-1:0] r_head_data;
  logic [CNT_W-1:0]  r_drop_cnt;

  logic              w_in_xfer;
  logic              w_out_xfer;
  logic              w_head_valid_nxt;
  logic [DATA_W-1:0] w_head_data_nxt;
  logic [1:0]        w_drop_n;
  logic [CNT_W:0]    w_drop_sum;
  logic [CNT_W-1:0]  w_drop_nxt;

  assign w_in_xfer  = in_valid && in_ready;
  assign w_out_xfer = r_head_valid && out_ready;

  // One extra bit catches the carry so the counter clamps at all-ones.
  assign w_drop_sum = {1'b0, r_drop_cnt} + {{(CNT_W-1){1'b0}}, w_drop_n};
  assign w_drop_nxt = w_drop_sum[CNT_W] ? {CNT_W{1'b1}} : w_drop_sum[CNT_W-1:0];

`ifdef PIPE_STAGE_SKID_EN

  logic              r_skid_valid;
  logic [DATA_W-1:0] r_skid_data;
  logic              r_skid_free;
  logic              w_skid_valid_nxt;
  logic [DATA_W-1:0] w_skid_data_nxt;

  // r_skid_free mirrors "skid empty" one register away from the upstream path,
  // so in_ready never depends combinationally on out_ready.
  assign in_ready = reset && !flush && r_skid_free;

  // A head beat leaving on the flush edge is a completed transfer, not a drop.
  assign w_drop_n = {1'b0, r_head_valid && !out_ready} + {1'b0, r_skid_valid};

  assign occupancy = {1'b0, r_head_valid} + {1'b0, r_skid_valid};

  always_comb begin
    w_head_valid_nxt = r_head_valid;
    w_head_data_nxt  = r_head_data;
    w_skid_valid_nxt = r_skid_valid;
    w_skid_data_nxt  = r_skid_data;
    if (flush) begin
      w_head_valid_nxt = 1'b0;
      w_head_data_nxt  = '0;
      w_skid_valid_nxt = 1'b0;
      w_skid_data_nxt  = '0;
    end else if (w_out_xfer) begin
      if (r_skid_valid) begin
        // Skid promotes to head; no input can arrive while skid is full.
        w_head_valid_nxt = 1'b1;
        w_head_data_nxt  = r_skid_data;
        w_skid_valid_nxt = 1'b0;
        w_skid_data_nxt  = '0;
      end else if (w_in_xfer) begin
        w_head_valid_nxt = 1'b1;
        w_head_data_nxt  = in_data;
      end else begin
        w_head_valid_nxt = 1'b0;
        w_head_data_nxt  = '0;
      end
    end else if (w_in_xfer) begin
      if (r_head_valid) begin
        w_skid_valid_nxt = 1'b1;
        w_skid_data_nxt  = in_data;
      end else begin
        w_head_valid_nxt = 1'b1;
        w_head_data_nxt  = in_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_skid_valid <= 1'b0;
      r_skid_data  <= '0;
      r_skid_free  <= 1'b1;
    end else begin
      r_skid_valid <= w_skid_valid_nxt;
      r_skid_data  <= w_skid_data_nxt;
      r_skid_free  <= !w_skid_valid_nxt;
    end
  end

`else

  // Single entry: accept when empty or when the held beat leaves this cycle.
  assign in_ready = reset && !flush && (!r_head_valid || out_ready);

  assign w_drop_n = {1'b0, r_head_valid && !out_ready};

  assign occupancy = {1'b0, r_head_valid};

  always_comb begin
    w_head_valid_nxt = r_head_valid;
    w_head_data_nxt  = r_head_data;
    if (flush) begin
      w_head_valid_nxt = 1'b0;
      w_head_data_nxt  = '0;
    end else if (w_in_xfer) begin
      w_head_valid_nxt = 1'b1;
      w_head_data_nxt  = in_data;
    end else if (w_out_xfer) begin
      // Drained head is zeroed so the bubble reads as all-zero.
      w_head_valid_nxt = 1'b0;
      w_head_data_nxt  = '0;
    end
  end

`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_head_valid <= 1'b0;
      r_head_data  <= '0;
      r_drop_cnt   <= '0;
    end else begin
      r_head_valid <= w_head_valid_nxt;
      r_head_data  <= w_head_data_nxt;
      if (flush) begin
        r_drop_cnt <= w_drop_nxt;
      end
    end
  end

  assign out_valid = r_head_valid;
  assign out_data  = r_head_data;
  assign drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - directed self-checking bench for pipe_stage_reg

module tb_pipe_stage_reg;

  localparam int DW = 230;
  localparam int CW = 4;
`ifdef PIPE_STAGE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif
  localparam int NENT = SKID ? 2 : 1;
  localparam int SAT  = (1 << CW) - 1;

  logic          clk;
  logic          reset;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [1:0]    occupancy;
  logic [CW-1:0] drop_cnt;

  int total;
  int bad;
  int d_exp;

  pipe_stage_reg #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy),
    .drop_cnt  (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] mk(input logic [7:0] b);
    return {{(DW-8){1'b0}}, b};
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    d_exp = 0;
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;

    // Reset for two cycles.
    tick();
    tick();
    chk("rst_in_ready",  256'(in_ready),  256'(0));
    chk("rst_out_valid", 256'(out_valid), 256'(0));
    chk("rst_out_data",  256'(out_data),  256'(0));
    chk("rst_occupancy", 256'(occupancy), 256'(0));
    chk("rst_drop_cnt",  256'(drop_cnt),  256'(0));
    reset = 1'b1;
    #1;
    chk("rel_in_ready", 256'(in_ready), 256'(1));

    // Stream 1,2,3 with one-cycle latency.
    in_valid = 1'b1; out_ready = 1'b1; in_data = mk(8'h01);
    tick();
    chk("s1_valid", 256'(out_valid), 256'(1));
    chk("s1_data",  256'(out_data),  256'(mk(8'h01)));
    in_data = mk(8'h02);
    tick();
    chk("s2_data",  256'(out_data),  256'(mk(8'h02)));
    in_data = mk(8'h03);
    tick();
    chk("s3_data",  256'(out_data),  256'(mk(8'h03)));
    in_valid = 1'b0;
    tick();
    chk("s_end_valid", 256'(out_valid), 256'(0));
    chk("s_end_data",  256'(out_data),  256'(0));
    chk("s_end_occ",   256'(occupancy), 256'(0));

    // Backpressure with 0xA5 held.
    out_ready = 1'b0; in_valid = 1'b1; in_data = mk(8'hA5);
    tick();
    chk("bp_head", 256'(out_data),  256'(mk(8'hA5)));
    chk("bp_occ1", 256'(occupancy), 256'(1));
    in_data = mk(8'h5A);
    #1;
    chk("bp_in_ready", 256'(in_ready), 256'(SKID));
    tick();
    chk("bp_hold1",     256'(out_data),  256'(mk(8'hA5)));
    chk("bp_occ2",      256'(occupancy), 256'(NENT));
    chk("bp_full_rdy",  256'(in_ready),  256'(0));
    in_valid = 1'b0;
    tick();
    chk("bp_hold2",  256'(out_data),  256'(mk(8'hA5)));
    chk("bp_valid2", 256'(out_valid), 256'(1));

    // Release: A5 leaves; skid variant then shows 5A.
    out_ready = 1'b1;
    tick();
    chk("rl_valid", 256'(out_valid), 256'(SKID));
    chk("rl_data",  256'(out_data),  SKID ? 256'(mk(8'h5A)) : 256'(0));
    chk("rl_rdy",   256'(in_ready),  256'(1));
    tick();
    chk("rl_empty_valid", 256'(out_valid), 256'(0));
    chk("rl_empty_data",  256'(out_data),  256'(0));

    // Flush with all entries full and out_ready low.
    out_ready = 1'b0; in_valid = 1'b1; in_data = mk(8'h11);
    tick();
    in_data = mk(8'h22);
    tick();
    in_valid = 1'b0;
    chk("fl_occ_pre", 256'(occupancy), 256'(NENT));
    flush = 1'b1;
    #1;
    chk("fl_in_ready", 256'(in_ready), 256'(0));
    tick();
    flush = 1'b0;
    d_exp = NENT;
    chk("fl_valid", 256'(out_valid), 256'(0));
    chk("fl_data",  256'(out_data),  256'(0));
    chk("fl_occ",   256'(occupancy), 256'(0));
    chk("fl_drop",  256'(drop_cnt),  256'(d_exp));

    // Flush coinciding with an out transfer: the leaving beat is not counted.
    in_valid = 1'b1; in_data = mk(8'h31);
    tick();
    in_data = mk(8'h32);
    tick();
    in_valid = 1'b0; out_ready = 1'b1; flush = 1'b1;
    tick();
    flush = 1'b0; out_ready = 1'b0;
    d_exp = d_exp + NENT - 1;
    chk("flx_drop",  256'(drop_cnt),  256'(d_exp));
    chk("flx_valid", 256'(out_valid), 256'(0));

    // Drive drop_cnt into saturation and hold there.
    for (int k = 0; k < 16; k++) begin
      in_valid = 1'b1; in_data = mk(8'h40 + 8'(k));
      tick();
      tick();
      in_valid = 1'b0; flush = 1'b1;
      tick();
      flush = 1'b0;
      d_exp = (d_exp + NENT > SAT) ? SAT : d_exp + NENT;
      chk("sat_step", 256'(drop_cnt), 256'(d_exp));
    end
    chk("sat_hold", 256'(drop_cnt), 256'(SAT));

    // Mid-stream reset discards beats without counting them.
    out_ready = 1'b1; in_valid = 1'b1; in_data = mk(8'h33);
    tick();
    chk("mr_pre_data", 256'(out_data), 256'(mk(8'h33)));
    out_ready = 1'b0; in_data = mk(8'h44);
    tick();
    in_valid = 1'b0; reset = 1'b0;
    #1;
    chk("mr_in_ready", 256'(in_ready), 256'(0));
    tick();
    chk("mr_valid", 256'(out_valid), 256'(0));
    chk("mr_data",  256'(out_data),  256'(0));
    chk("mr_occ",   256'(occupancy), 256'(0));
    chk("mr_drop",  256'(drop_cnt),  256'(0));
    reset = 1'b1; in_valid = 1'b1; in_data = mk(8'h77); out_ready = 1'b1;
    tick();
    chk("mr_next_valid", 256'(out_valid), 256'(1));
    chk("mr_next_data",  256'(out_data),  256'(mk(8'h77)));
    in_valid = 1'b0;
    tick();
    chk("mr_drain_valid", 256'(out_valid), 256'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
